// File: rtl/biu_pkg.sv
// biu_pkg: shared state/op encodings and default widths for the bus interface unit
package biu_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic {OP_READ = 1'b0, OP_WRITE = 1'b1} op_t;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W = 4;
endpackage

// File: rtl/biu_wait_counter.sv
// biu_wait_counter: loadable 4-bit down-counter that stops at zero and flags it
module biu_wait_counter import biu_pkg::*; (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clock or negedge reset)
    if (!reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/bus_interface_unit.sv
// bus_interface_unit: latches CPU accesses, runs them on the memory port with wait states and ready handshake.
// Optional BIU_PARITY_EN adds mem_rpar input and a parity_err pulse on read completion.
module bus_interface_unit import biu_pkg::*; #(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_STATES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              illegal_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
`ifdef BIU_PARITY_EN
  ,input  logic             mem_rpar,
  output logic              parity_err
`endif
);
  localparam logic [CNT_W-1:0] WS = CNT_W'(WAIT_STATES);
  state_t state;
  op_t    op;
  logic   zero;
  logic   req;
  assign req = req_read || req_write;
  biu_wait_counter u_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (state == IDLE && req),
    .load_val (WS),
    .dec      (state == ACCESS),
    .zero     (zero)
  );
  // mem_addr/mem_wdata double as the request latches; read wins a collision
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state       <= IDLE;
      op          <= OP_READ;
      busy        <= 1'b0;
      ack         <= 1'b0;
      illegal_req <= 1'b0;
      rdata       <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
`ifdef BIU_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      ack         <= 1'b0;
      illegal_req <= 1'b0;
`ifdef BIU_PARITY_EN
      parity_err  <= 1'b0;
`endif
      case (state)
        IDLE: if (req) begin
          state       <= ACCESS;
          busy        <= 1'b1;
          mem_addr    <= req_addr;
          mem_wdata   <= req_wdata;
          op          <= req_read ? OP_READ : OP_WRITE;
          mem_re      <= req_read;
          mem_we      <= !req_read;
          illegal_req <= req_read && req_write;
        end
        ACCESS: if (zero && mem_ready) begin
          state  <= DONE;
          mem_re <= 1'b0;
          mem_we <= 1'b0;
          ack    <= 1'b1;
          if (op == OP_READ) rdata <= mem_rdata;
`ifdef BIU_PARITY_EN
          if (op == OP_READ) parity_err <= ^mem_rdata ^ mem_rpar;
`endif
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_bus_interface_unit.sv
// tb_bus_interface_unit: directed vector table plus stall, reset and parity sequences
module tb_bus_interface_unit;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;
  logic       req_read = 1'b0, req_write = 1'b0;
  logic [4:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       ready0 = 1'b1, ready1 = 1'b1;
  logic       busy0, busy1, ack0, ack1, ill0, ill1, re0, re1, we0, we1;
  logic [7:0] rdata0, rdata1, wd0, wd1, rd0, rd1;
  logic [4:0] ma0, ma1;
  logic [7:0] mem0 [32];
  logic [7:0] mem1 [32];
`ifdef BIU_PARITY_EN
  logic rpar = 1'b0;
  logic perr0, perr1;
`endif
  int total = 0, bad = 0;
  int lat, nre, nwe, nill, nack, nack0, nill0;
  logic [4:0] a_seen;
  logic [7:0] d_seen;
  logic b_seen, p_seen;

  bus_interface_unit #(.ADDR_W(5), .DATA_W(8), .WAIT_STATES(0)) u0 (
    .clock(clock), .reset(reset), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy0), .ack(ack0),
    .rdata(rdata0), .illegal_req(ill0), .mem_addr(ma0), .mem_wdata(wd0),
    .mem_re(re0), .mem_we(we0), .mem_rdata(rd0), .mem_ready(ready0)
`ifdef BIU_PARITY_EN
    , .mem_rpar(rpar), .parity_err(perr0)
`endif
  );
  bus_interface_unit #(.ADDR_W(5), .DATA_W(8), .WAIT_STATES(1)) u1 (
    .clock(clock), .reset(reset), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy1), .ack(ack1),
    .rdata(rdata1), .illegal_req(ill1), .mem_addr(ma1), .mem_wdata(wd1),
    .mem_re(re1), .mem_we(we1), .mem_rdata(rd1), .mem_ready(ready1)
`ifdef BIU_PARITY_EN
    , .mem_rpar(rpar), .parity_err(perr1)
`endif
  );

  function automatic logic [7:0] init_val(int i);
    return i == 3 ? 8'hA5 : i == 1 ? 8'h01 : 8'h40 | 8'(i);
  endfunction
  assign rd0 = mem0[ma0];
  assign rd1 = mem1[ma1];
  always @(posedge clock)
    if (!reset) for (int i = 0; i < 32; i++) mem0[i] <= init_val(i);
    else if (we0 && ready0) mem0[ma0] <= wd0;
  always @(posedge clock)
    if (!reset) for (int i = 0; i < 32; i++) mem1[i] <= init_val(i);
    else if (we1 && ready1) mem1[ma1] <= wd1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // one-cycle request pulse on both units, then follow u1 until ack (bounded)
  task automatic run(input logic rd, input logic wr, input logic [4:0] a, input logic [7:0] d);
    @(negedge clock);
    req_read = rd; req_write = wr; req_addr = a; req_wdata = d;
    @(negedge clock);
    req_read = 1'b0; req_write = 1'b0;
    lat = 0; nre = 0; nwe = 0; nill = 0; p_seen = 1'b0;
    a_seen = ma1; d_seen = wd1; b_seen = busy1;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clock);
      nre += int'(re1);
      nwe += int'(we1);
      nill += int'(ill1);
      if (ack1) begin
        lat = k;
`ifdef BIU_PARITY_EN
        p_seen = perr1;
`endif
        break;
      end
    end
    @(negedge clock);
  endtask

  typedef struct {
    logic rd, wr;
    logic [4:0] a;
    logic [7:0] d, exp_rdata;
    int exp_re, exp_we, exp_ill;
  } vec_t;
  vec_t vecs [8];

  initial begin
    vecs[0] = '{1, 0, 5'h03, 8'h00, 8'hA5, 2, 0, 0};
    vecs[1] = '{0, 1, 5'h10, 8'h3C, 8'hA5, 0, 2, 0};
    vecs[2] = '{1, 0, 5'h10, 8'h00, 8'h3C, 2, 0, 0};
    vecs[3] = '{1, 1, 5'h07, 8'hFF, 8'h47, 2, 0, 1};
    vecs[4] = '{1, 0, 5'h01, 8'h00, 8'h01, 2, 0, 0};
    vecs[5] = '{0, 1, 5'h1F, 8'h99, 8'h01, 0, 2, 0};
    vecs[6] = '{1, 0, 5'h1F, 8'h00, 8'h99, 2, 0, 0};
    vecs[7] = '{1, 0, 5'h00, 8'h00, 8'h40, 2, 0, 0};
    repeat (2) @(negedge clock);
    chk("rst busy", busy1, 0);
    chk("rst ack", ack1, 0);
    chk("rst rdata", rdata1, 0);
    chk("rst mem_re", re1, 0);
    chk("rst mem_we", we1, 0);
    chk("rst mem_addr", ma1, 0);
    chk("rst mem_wdata", wd1, 0);
    chk("rst illegal", ill1, 0);
    chk("rst busy0", busy0, 0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d);
      chk($sformatf("v%0d latency", i), lat, 3);
      chk($sformatf("v%0d busy", i), b_seen, 1);
      chk($sformatf("v%0d mem_addr", i), a_seen, vecs[i].a);
      chk($sformatf("v%0d re cycles", i), nre, vecs[i].exp_re);
      chk($sformatf("v%0d we cycles", i), nwe, vecs[i].exp_we);
      chk($sformatf("v%0d illegal", i), nill, vecs[i].exp_ill);
      chk($sformatf("v%0d rdata", i), rdata1, vecs[i].exp_rdata);
      if (vecs[i].wr && !vecs[i].rd) chk($sformatf("v%0d mem_wdata", i), d_seen, vecs[i].d);
    end
    // memory stall on the zero-wait-state unit
    ready0 = 1'b0;
    nill0 = 0;
    @(negedge clock);
    req_read = 1'b1; req_addr = 5'h05;
    @(negedge clock);
    req_read = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stall%0d busy", i), busy0, 1);
      chk($sformatf("stall%0d addr", i), ma0, 5'h05);
      chk($sformatf("stall%0d re", i), re0, 1);
      chk($sformatf("stall%0d ack", i), ack0, 0);
      nill0 += int'(ill0);
      @(negedge clock);
    end
    chk("stall ack held", ack0, 0);
    ready0 = 1'b1;
    @(negedge clock);
    chk("stall ack", ack0, 1);
    chk("stall rdata", rdata0, 8'h45);
    chk("stall re off", re0, 0);
    @(negedge clock);
    chk("stall ack pulse", ack0, 0);
    chk("stall no illegal", nill0, 0);
    repeat (3) @(negedge clock);
    // asynchronous reset in the middle of an access
    @(negedge clock);
    req_read = 1'b1; req_addr = 5'h03;
    @(negedge clock);
    req_read = 1'b0;
    chk("mid re before", re1, 1);
    reset = 1'b0;
    #1;
    chk("mid re", re1, 0);
    chk("mid busy", busy1, 0);
    chk("mid rdata", rdata1, 0);
    @(negedge clock);
    reset = 1'b1;
    nack = 0;
    nack0 = 0;
    repeat (6) begin
      @(negedge clock);
      nack += int'(ack1);
      nack0 += int'(ack0);
    end
    chk("mid no ack", nack, 0);
    chk("mid no ack0", nack0, 0);
    run(1'b1, 1'b0, 5'h03, 8'h00);
    chk("post latency", lat, 3);
    chk("post rdata", rdata1, 8'hA5);
`ifdef BIU_PARITY_EN
    rpar = 1'b0;
    run(1'b1, 1'b0, 5'h01, 8'h00);
    chk("parity err", p_seen, 1);
    chk("parity rdata", rdata1, 8'h01);
    rpar = 1'b1;
    run(1'b1, 1'b0, 5'h01, 8'h00);
    chk("parity ok", p_seen, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
